pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
Lock-acquisition controller for the PLL error-processing unit (EPU) and loop filter. Sequences acquisition from start-up through coarse frequency lock, fine lock, and steady tracking:
- drives the EPU enable and the frequency-lock window (freq_lock_range);
- selects the loop-filter gain set;
- watches the EPU freq_locked/phase_locked flags, bounds each phase with a timeout, and handles relock after lock loss.
Sits beside the EPU in the clk_ref domain, between the chip configuration registers and the EPU/loop filter.

Parameters:
N_SIZE, 8, width of the divider/target ratio n (matches EPU)
TIMER_W, 16, width of the phase timer
SETTLE_CYCLES, 16, clk_ref cycles spent in SETTLE before COARSE
COARSE_TIMEOUT, 20000, max cycles in COARSE before FAULT (must exceed 1000, the EPU lock-count depth)
FINE_TIMEOUT, 20000, max cycles in FINE before FAULT (must exceed 1000)
LOSS_LIMIT, 3, lock losses tolerated since last start; reaching it forces FAULT

Ports:
clk_ref  input  1  reference clock; only clock
rst  input  1  synchronous, active-high reset
start  input  1  level/pulse request to begin acquisition
abort  input  1  return to IDLE
n_target  input  N_SIZE  requested ratio, forwarded to EPU n
freq_locked  input  1  EPU frequency-lock flag
phase_locked  input  1  EPU phase-lock flag
epu_enable  output  1  EPU/counter enable
epu_n  output  N_SIZE  registered copy of n_target captured at start
freq_lock_range  output  2  EPU lock window
gain_sel  output  2  loop-filter gain set: 0 wide, 1 medium, 2 narrow
lock_done  output  1  high only in TRACK
fault  output  1  high only in FAULT
state_out  output  3  current state encoding
relock_count  output  4  lock losses since last start, saturating at 15

Behaviour:
- One clock (clk_ref); reset is synchronous and active-high.
- All outputs are registered and follow the state register.
- State encodings: IDLE=0, SETTLE=1, COARSE=2, FINE=3, TRACK=4, FAULT=5.
- Reset values: state IDLE, epu_enable 0, epu_n 0, freq_lock_range 3, gain_sel 0, lock_done 0, fault 0, relock_count 0, timer 0.
- Priority, highest first: rst > abort > n_target change > state transitions.
- abort in any state: IDLE on the next edge. relock_count is retained until the next start.
- n_target change while in SETTLE, COARSE, FINE or TRACK:
  - recapture epu_n;
  - go to SETTLE;
  - relock_count unchanged;
  - not counted as a loss.
- Timer: cleared on every state entry, increments each cycle in the state, saturates at all-ones.
- Per-state outputs (epu_enable, range, gain_sel; lock_done and fault are 0 except where stated):
  - IDLE: 0, 3, 0.
  - SETTLE: 1, 3, 0.
  - COARSE: 1, 3, 0.
  - FINE: 1, 1, 1.
  - TRACK: 1, 1, 2; lock_done=1.
  - FAULT: 0, 3, 0; fault=1.
- IDLE: start=1 -> SETTLE. Capture epu_n=n_target and clear relock_count.
- SETTLE: when timer == SETTLE_CYCLES-1 -> COARSE. Total dwell is SETTLE_CYCLES cycles.
- COARSE:
  - freq_locked=1 -> FINE;
  - else if timer == COARSE_TIMEOUT-1 -> FAULT;
  - if both hold in the same cycle, freq_locked wins.
- FINE (first match wins):
  - phase_locked=1 -> TRACK;
  - else freq_locked=0 -> COARSE, not a loss;
  - else timer == FINE_TIMEOUT-1 -> FAULT.
- TRACK: phase_locked=0 is a loss.
  - relock_count increments, saturating at 15.
  - If the new count >= LOSS_LIMIT -> FAULT.
  - Otherwise -> FINE if freq_locked=1, else COARSE.
  - No timeout applies in TRACK.
- FAULT: holds until abort (-> IDLE) or start (-> SETTLE, recapture epu_n, clear relock_count).
- start is ignored outside IDLE and FAULT.
- rst asserted mid-operation: all registers take reset values on that edge, regardless of other inputs.

Test Plan:
(Bench parameters: SETTLE_CYCLES=4, COARSE_TIMEOUT=50, FINE_TIMEOUT=50, LOSS_LIMIT=3.)
- Nominal acquisition:
  - Stimulus: rst, then start with n_target=8'd100; freq_locked=1 at cycle 20; phase_locked=1 at cycle 30.
  - Response: state 0->1 for 4 cycles, ->2, ->3 the edge after freq_locked rises, ->4 the edge after phase_locked rises.
  - Response: epu_n=100, gain_sel 0->1->2, lock_done=1 only in TRACK.
- Coarse timeout:
  - Stimulus: start; freq_locked held 0.
  - Response: FAULT exactly 50 cycles after COARSE entry; fault=1, epu_enable=0.
  - Follow-up: start again -> SETTLE, relock_count=0.
- Loss handling:
  - Stimulus: from TRACK, three phase_locked drops, each with freq_locked=1, relocking between drops.
  - Response: relock_count 1 -> FINE, 2 -> FINE, 3 -> FAULT.
  - Variant: one drop with freq_locked=0 -> COARSE.
- Retarget:
  - Stimulus: in TRACK, n_target changes 100->120.
  - Response: next edge SETTLE with epu_n=120, lock_done=0, relock_count unchanged.
- Priority:
  - Stimulus: abort and an n_target change in the same cycle in FINE.
  - Response: IDLE.
  - Stimulus: rst and start in the same cycle from IDLE.
  - Response: stays IDLE with all outputs at reset values.
- Boundary:
  - Stimulus: in COARSE, freq_locked rises on the timeout cycle (timer=49).
  - Response: FINE, not FAULT.
  - Stimulus: start pulsed during COARSE.
  - Response: no effect.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_sequencer
//  Brief    : Lock-acquisition controller steering the PLL EPU and loop filter
//             through settle, coarse lock, fine lock and tracking.
//  Revision : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
    parameter int N_SIZE         = 8,
    parameter int TIMER_W        = 16,
    parameter int SETTLE_CYCLES  = 16,
    parameter int COARSE_TIMEOUT = 20000,
    parameter int FINE_TIMEOUT   = 20000,
    parameter int LOSS_LIMIT     = 3
) (
    input  logic              clk_ref,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [N_SIZE-1:0] n_target,
    input  logic              freq_locked,
    input  logic              phase_locked,
    output logic              epu_enable,
    output logic [N_SIZE-1:0] epu_n,
    output logic [1:0]        freq_lock_range,
    output logic [1:0]        gain_sel,
    output logic              lock_done,
    output logic              fault,
    output logic [2:0]        state_out,
    output logic [3:0]        relock_count
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_settle = 3'd1;
    localparam logic [2:0] c_st_coarse = 3'd2;
    localparam logic [2:0] c_st_fine   = 3'd3;
    localparam logic [2:0] c_st_track  = 3'd4;
    localparam logic [2:0] c_st_fault  = 3'd5;

    localparam logic [TIMER_W-1:0] c_settle_last = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_coarse_last = TIMER_W'(COARSE_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] c_fine_last   = TIMER_W'(FINE_TIMEOUT - 1);
    localparam logic [3:0]         c_loss_limit  = 4'(LOSS_LIMIT);

    logic [2:0]         r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [N_SIZE-1:0]  r_epu_n;
    logic [3:0]         r_relock_count;

    logic [2:0] w_nxt_state;
    logic       w_enter;
    logic       w_capture;
    logic       w_clr_cnt;
    logic       w_loss;
    logic       w_retarget;
    logic [3:0] w_cnt_inc;
    logic       w_nxt_enable;
    logic [1:0] w_nxt_range;
    logic [1:0] w_nxt_gain;

    assign w_cnt_inc  = (r_relock_count == 4'hF) ? 4'hF : r_relock_count + 4'd1;
    assign w_retarget = (r_state == c_st_settle || r_state == c_st_coarse ||
                         r_state == c_st_fine   || r_state == c_st_track) &&
                        (n_target != r_epu_n);

    always_comb begin
        w_nxt_state = r_state;
        w_enter     = 1'b0;
        w_capture   = 1'b0;
        w_clr_cnt   = 1'b0;
        w_loss      = 1'b0;
        if (abort) begin
            w_nxt_state = c_st_idle;
            w_enter     = 1'b1;
        end else if (w_retarget) begin
            // A retarget restarts acquisition but is not a lock loss.
            w_nxt_state = c_st_settle;
            w_enter     = 1'b1;
            w_capture   = 1'b1;
        end else begin
            case (r_state)
                c_st_idle, c_st_fault: begin
                    if (start) begin
                        w_nxt_state = c_st_settle;
                        w_enter     = 1'b1;
                        w_capture   = 1'b1;
                        w_clr_cnt   = 1'b1;
                    end
                end
                c_st_settle: begin
                    if (r_timer == c_settle_last) begin
                        w_nxt_state = c_st_coarse;
                        w_enter     = 1'b1;
                    end
                end
                c_st_coarse: begin
                    if (freq_locked) begin
                        w_nxt_state = c_st_fine;
                        w_enter     = 1'b1;
                    end else if (r_timer == c_coarse_last) begin
                        w_nxt_state = c_st_fault;
                        w_enter     = 1'b1;
                    end
                end
                c_st_fine: begin
                    if (phase_locked) begin
                        w_nxt_state = c_st_track;
                        w_enter     = 1'b1;
                    end else if (!freq_locked) begin
                        w_nxt_state = c_st_coarse;
                        w_enter     = 1'b1;
                    end else if (r_timer == c_fine_last) begin
                        w_nxt_state = c_st_fault;
                        w_enter     = 1'b1;
                    end
                end
                c_st_track: begin
                    if (!phase_locked) begin
                        w_loss  = 1'b1;
                        w_enter = 1'b1;
                        if (w_cnt_inc >= c_loss_limit) w_nxt_state = c_st_fault;
                        else if (freq_locked)          w_nxt_state = c_st_fine;
                        else                           w_nxt_state = c_st_coarse;
                    end
                end
                default: begin
                    w_nxt_state = c_st_idle;
                    w_enter     = 1'b1;
                end
            endcase
        end
    end

    // Output decode is done on the next state so registered outputs line up with r_state.
    always_comb begin
        w_nxt_enable = 1'b0;
        w_nxt_range  = 2'd3;
        w_nxt_gain   = 2'd0;
        case (w_nxt_state)
            c_st_settle, c_st_coarse: w_nxt_enable = 1'b1;
            c_st_fine: begin
                w_nxt_enable = 1'b1;
                w_nxt_range  = 2'd1;
                w_nxt_gain   = 2'd1;
            end
            c_st_track: begin
                w_nxt_enable = 1'b1;
                w_nxt_range  = 2'd1;
                w_nxt_gain   = 2'd2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            r_state         <= c_st_idle;
            r_timer         <= '0;
            r_epu_n         <= '0;
            r_relock_count  <= 4'd0;
            epu_enable      <= 1'b0;
            freq_lock_range <= 2'd3;
            gain_sel        <= 2'd0;
            lock_done       <= 1'b0;
            fault           <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            if (w_enter)               r_timer <= '0;
            else if (r_timer != '1)    r_timer <= r_timer + 1'b1;
            if (w_capture) r_epu_n <= n_target;
            if (w_clr_cnt)   r_relock_count <= 4'd0;
            else if (w_loss) r_relock_count <= w_cnt_inc;
            epu_enable      <= w_nxt_enable;
            freq_lock_range <= w_nxt_range;
            gain_sel        <= w_nxt_gain;
            lock_done       <= (w_nxt_state == c_st_track);
            fault           <= (w_nxt_state == c_st_fault);
        end
    end

    assign epu_n        = r_epu_n;
    assign state_out    = r_state;
    assign relock_count = r_relock_count;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pll_lock_sequencer
//  Brief    : Directed self-checking bench for pll_lock_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;

    logic       clk_ref = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] n_target = 8'd0;
    logic       freq_locked = 1'b0;
    logic       phase_locked = 1'b0;
    logic       epu_enable;
    logic [7:0] epu_n;
    logic [1:0] freq_lock_range;
    logic [1:0] gain_sel;
    logic       lock_done;
    logic       fault;
    logic [2:0] state_out;
    logic [3:0] relock_count;

    int r_vec_cnt = 0;
    int r_err_cnt = 0;

    pll_lock_sequencer #(
        .N_SIZE(8), .TIMER_W(16), .SETTLE_CYCLES(4),
        .COARSE_TIMEOUT(50), .FINE_TIMEOUT(50), .LOSS_LIMIT(3)
    ) u_dut (
        .clk_ref(clk_ref), .rst(rst), .start(start), .abort(abort),
        .n_target(n_target), .freq_locked(freq_locked), .phase_locked(phase_locked),
        .epu_enable(epu_enable), .epu_n(epu_n), .freq_lock_range(freq_lock_range),
        .gain_sel(gain_sel), .lock_done(lock_done), .fault(fault),
        .state_out(state_out), .relock_count(relock_count)
    );

    always #5 clk_ref = ~clk_ref;

    task automatic chk(input string tag, input int observed, input int expected);
        r_vec_cnt++;
        if (observed !== expected) begin
            r_err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance n edges; inputs and samples sit 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_ref);
        #1;
    endtask

    // state, enable, range, gain, lock_done, fault packed for one comparison
    task automatic chk_st(input string tag, input int st, input int en,
                          input int rng, input int gn, input int ld, input int flt);
        chk({tag, ".state"}, state_out, st);
        chk({tag, ".outs"}, {epu_enable, freq_lock_range, gain_sel, lock_done, fault},
            (en << 6) | (rng << 4) | (gn << 2) | (ld << 1) | flt);
    endtask

    initial begin
        tick(2);
        chk_st("reset", 0, 0, 3, 0, 0, 0);
        chk("reset.epu_n", epu_n, 0);
        chk("reset.relock", relock_count, 0);
        rst = 1'b0;

        // Nominal acquisition
        n_target = 8'd100; start = 1'b1;
        tick(1); start = 1'b0;
        chk_st("nom.settle", 1, 1, 3, 0, 0, 0);
        chk("nom.epu_n", epu_n, 100);
        tick(3);
        chk_st("nom.settle_end", 1, 1, 3, 0, 0, 0);
        tick(1);
        chk_st("nom.coarse", 2, 1, 3, 0, 0, 0);
        tick(15);
        chk_st("nom.coarse_wait", 2, 1, 3, 0, 0, 0);
        freq_locked = 1'b1;
        tick(1);
        chk_st("nom.fine", 3, 1, 1, 1, 0, 0);
        tick(9);
        chk_st("nom.fine_wait", 3, 1, 1, 1, 0, 0);
        phase_locked = 1'b1;
        tick(1);
        chk_st("nom.track", 4, 1, 1, 2, 1, 0);

        // Retarget from TRACK
        n_target = 8'd120;
        tick(1);
        chk_st("rt.settle", 1, 1, 3, 0, 0, 0);
        chk("rt.epu_n", epu_n, 120);
        chk("rt.relock", relock_count, 0);
        tick(4);
        chk("rt.coarse", state_out, 2);
        tick(1);
        chk("rt.fine", state_out, 3);
        tick(1);
        chk("rt.track", state_out, 4);

        // Three losses with freq lock held
        phase_locked = 1'b0;
        tick(1);
        chk_st("loss1", 3, 1, 1, 1, 0, 0);
        chk("loss1.cnt", relock_count, 1);
        phase_locked = 1'b1;
        tick(1);
        chk("loss1.relock", state_out, 4);
        phase_locked = 1'b0;
        tick(1);
        chk("loss2", state_out, 3);
        chk("loss2.cnt", relock_count, 2);
        phase_locked = 1'b1;
        tick(1);
        chk("loss2.relock", state_out, 4);
        phase_locked = 1'b0;
        tick(1);
        chk_st("loss3", 5, 0, 3, 0, 0, 1);
        chk("loss3.cnt", relock_count, 3);

        // Restart from FAULT, then a loss with freq lock gone
        start = 1'b1;
        tick(1); start = 1'b0;
        chk("restart.state", state_out, 1);
        chk("restart.cnt", relock_count, 0);
        tick(5);
        chk("restart.fine", state_out, 3);
        phase_locked = 1'b1;
        tick(1);
        chk("restart.track", state_out, 4);
        phase_locked = 1'b0; freq_locked = 1'b0;
        tick(1);
        chk_st("lossv.coarse", 2, 1, 3, 0, 0, 0);
        chk("lossv.cnt", relock_count, 1);

        // abort keeps relock_count
        abort = 1'b1;
        tick(1); abort = 1'b0;
        chk_st("abort.idle", 0, 0, 3, 0, 0, 0);
        chk("abort.cnt", relock_count, 1);

        // Coarse timeout, with a start pulse in COARSE that must be ignored
        start = 1'b1;
        tick(1); start = 1'b0;
        chk("to.settle_cnt", relock_count, 0);
        tick(4);
        chk("to.coarse", state_out, 2);
        start = 1'b1;
        tick(1); start = 1'b0;
        chk("to.start_ignored", state_out, 2);
        tick(48);
        chk("to.last_coarse", state_out, 2);
        tick(1);
        chk_st("to.fault", 5, 0, 3, 0, 0, 1);
        tick(3);
        chk("to.fault_hold", state_out, 5);
        start = 1'b1;
        tick(1); start = 1'b0;
        chk("to.restart", state_out, 1);
        chk("to.restart_cnt", relock_count, 0);

        // freq_locked arriving on the timeout cycle wins
        tick(4);
        chk("bd.coarse", state_out, 2);
        tick(49);
        freq_locked = 1'b1;
        tick(1);
        chk("bd.fine_not_fault", state_out, 3);

        // abort beats a simultaneous retarget in FINE
        abort = 1'b1; n_target = 8'd77;
        tick(1); abort = 1'b0;
        chk("pri.idle", state_out, 0);
        chk("pri.epu_n", epu_n, 120);
        tick(1);
        chk("pri.idle_hold", state_out, 0);

        // rst beats start from IDLE
        rst = 1'b1; start = 1'b1;
        tick(1); rst = 1'b0; start = 1'b0;
        chk_st("rst.idle", 0, 0, 3, 0, 0, 0);
        chk("rst.epu_n", epu_n, 0);
        chk("rst.cnt", relock_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", r_vec_cnt, r_err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
